accum_differencer: RTL and testbench
====================================

# accum_differencer

Inverse of the saturating accumulator: consumes a stream of signed accumulator samples (ACCUM_SZ bits) and recovers the per-sample increments. Each output is the first difference, current sample minus previous sample, saturated to DATA_SZ bits. It sits on the consumer side of an accumulator output, for example in loopback checking or decimation paths. Input and output both use valid/ready handshakes. The block keeps a saturation event counter for debug.

## Interface
- ACCUM_SZ, 32, width of input samples (two's complement)
- DATA_SZ, 16, width of output differences (two's complement); must be ≤ ACCUM_SZ
- SAT_CNT_SZ, 8, width of saturation event counter
- clk  input  1  clock, all logic on rising edge
- reset  input  1  asynchronous, active-low reset
- clear  input  1  synchronous restart of differencing history
- in_valid  input  1  in_data is valid
- in_ready  output  1  block can accept in_data this cycle
- in_data  input  ACCUM_SZ  accumulator sample, signed
- out_valid  output  1  out_data/out_sat valid
- out_ready  input  1  downstream accepts output this cycle
- out_data  output  DATA_SZ  saturated difference, signed
- out_sat  output  1  out_data was clamped
- sat_count  output  SAT_CNT_SZ  number of saturated results since reset/clear, sticky at max

## Operation
- Internal state: prev_reg (ACCUM_SZ), output register {out_data, out_sat}, out_valid, sat_count.
- Input accept when in_valid && in_ready && !clear.
- Output handoff when out_valid && out_ready.
- in_ready = !clear && (!out_valid || out_ready). This is combinational, with no dependence on in_valid.
- Arithmetic on accept:
  - diff = sign-extend(in_data) − sign-extend(prev_reg), computed at ACCUM_SZ+1 bits so it never wraps.
  - If diff > 2^(DATA_SZ−1)−1: out_data = {0, all 1s}, out_sat = 1.
  - Else if diff < −2^(DATA_SZ−1): out_data = {1, all 0s}, out_sat = 1.
  - Otherwise out_data = diff[DATA_SZ−1:0], out_sat = 0.
- On accept, prev_reg ← in_data. This happens regardless of saturation.
- Initial prev_reg = 0. This matches the accumulator's reset value, so the first difference equals the first increment.
- Output register state machine, two states:
  - EMPTY (out_valid = 0).
  - FULL (out_valid = 1).
  - EMPTY→FULL on accept.
  - FULL→FULL on accept with simultaneous handoff; the register is reloaded.
  - FULL→EMPTY on handoff without accept.
  - FULL holds on no handoff. out_data and out_sat must remain stable while out_valid && !out_ready.
- sat_count increments on each accept with out_sat result. It saturates at 2^SAT_CNT_SZ−1 and never wraps.
- clear (synchronous, highest priority after reset):
  - Next cycle: prev_reg = 0, out_valid = 0, out_data = 0, out_sat = 0, sat_count = 0.
  - Any simultaneous input is not accepted, because in_ready is 0.
  - Any pending output is discarded.

## Timing
- Reset (async, immediate on reset low): out_valid 0, out_data 0, out_sat 0, sat_count 0, prev_reg 0. in_ready reads 1 once reset is released and clear = 0.
- Latency: a sample accepted at edge N has its result visible with out_valid = 1 immediately after edge N.
- Throughput: one sample per cycle when out_ready is held at 1.
- Backpressure:
  - When out_valid = 1 and out_ready = 0, in_ready = 0 in the same cycle.
  - No sample is lost or duplicated.
- Reset mid-transfer: all state clears asynchronously. The first post-reset sample is differenced against 0.
- Simultaneous clear and out_ready with out_valid = 1: the handoff is not counted as a transfer obligation. Downstream must treat clear as a flush.

## Test plan
- Stream: reset, out_ready = 1, inputs 5, 12, 12, −4 on consecutive cycles → outputs 5, 7, 0, −16 with out_sat = 0 and one-cycle latency, in_ready constantly 1.
- Backpressure: accept 100, then hold out_ready = 0 for 4 cycles while in_valid = 1 with 150.
  - Expected: in_ready = 0 and out_data = 100 held stable.
  - Then release out_ready: output 50 follows with no loss or duplicate.
- Saturation: from prev 0, input 0x0001_0000 → 0x7FFF, out_sat = 1, sat_count = 1. Then input 0 → 0x8000, out_sat = 1, sat_count = 2. Then input 3 → 3, out_sat = 0.
- Full-range: inputs 0x7FFF_FFFF then 0x8000_0000.
  - Expected: first output 0x7FFF (sat); second output 0x8000 (sat).
  - No wrap to a positive value.
- clear mid-stream: prev = 1000 with out_valid = 1 and out_ready = 0. Assert clear for one cycle while in_valid = 1 with 2000.
  - Expected: in_ready = 0 during clear; next cycle out_valid = 0 and sat_count = 0.
  - Then input 7 → output 7.
- Counter saturation (SAT_CNT_SZ = 8): 300 alternating inputs ±0x0010_0000 → sat_count stops at 255. Then an async reset pulse → all outputs 0 before the next clk edge.

Source files
------------

// File: rtl/accum_differencer.sv
// First-difference recovery of a signed accumulator stream. Each output is the
// current sample minus the previous one, saturated to DATA_SZ bits, and sits in
// a one-entry output register with valid/ready handshakes.
module accum_differencer #(
    parameter int ACCUM_SZ   = 32,
    parameter int DATA_SZ    = 16,
    parameter int SAT_CNT_SZ = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clear,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [ACCUM_SZ-1:0]   in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_SZ-1:0]    out_data,
    output logic                  out_sat,
    output logic [SAT_CNT_SZ-1:0] sat_count
);

    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_e;

    // Clamp limits sign-extended to the ACCUM_SZ+1 difference width.
    localparam logic signed [ACCUM_SZ:0] MAX_DIFF =
        {{(ACCUM_SZ-DATA_SZ+1){1'b0}}, 1'b0, {(DATA_SZ-1){1'b1}}};
    localparam logic signed [ACCUM_SZ:0] MIN_DIFF =
        {{(ACCUM_SZ-DATA_SZ+1){1'b1}}, 1'b1, {(DATA_SZ-1){1'b0}}};

    state_e                       state_q, state_d;
    logic signed [ACCUM_SZ-1:0]   prev_q, prev_d;
    logic signed [DATA_SZ-1:0]    data_q, data_d;
    logic                         sat_q, sat_d;
    logic [SAT_CNT_SZ-1:0]        cnt_q, cnt_d;

    logic signed [ACCUM_SZ:0]     diff;
    logic [DATA_SZ:0]             sat_res;
    logic                         accept;
    logic                         handoff;

    // Returns {saturated, value}.
    function automatic logic [DATA_SZ:0] sat_diff(input logic signed [ACCUM_SZ:0] d);
        if (d > MAX_DIFF) begin
            return {1'b1, 1'b0, {(DATA_SZ-1){1'b1}}};
        end else if (d < MIN_DIFF) begin
            return {1'b1, 1'b1, {(DATA_SZ-1){1'b0}}};
        end else begin
            return {1'b0, d[DATA_SZ-1:0]};
        end
    endfunction

    assign diff    = $signed({in_data[ACCUM_SZ-1], in_data}) - $signed({prev_q[ACCUM_SZ-1], prev_q});
    assign sat_res = sat_diff(diff);

    assign in_ready  = !clear && ((state_q == EMPTY) || out_ready);
    assign accept    = in_valid && in_ready;
    assign handoff   = (state_q == FULL) && out_ready;

    assign out_valid = (state_q == FULL);
    assign out_data  = data_q;
    assign out_sat   = sat_q;
    assign sat_count = cnt_q;

    always_comb begin
        state_d = state_q;
        prev_d  = prev_q;
        data_d  = data_q;
        sat_d   = sat_q;
        cnt_d   = cnt_q;
        if (clear) begin
            state_d = EMPTY;
            prev_d  = '0;
            data_d  = '0;
            sat_d   = 1'b0;
            cnt_d   = '0;
        end else if (accept) begin
            state_d = FULL;
            prev_d  = $signed(in_data);
            data_d  = $signed(sat_res[DATA_SZ-1:0]);
            sat_d   = sat_res[DATA_SZ];
            if (sat_res[DATA_SZ] && (cnt_q != {SAT_CNT_SZ{1'b1}})) begin
                cnt_d = cnt_q + 1'b1;
            end
        end else if (handoff) begin
            state_d = EMPTY;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= EMPTY;
            prev_q  <= '0;
            data_q  <= '0;
            sat_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            prev_q  <= prev_d;
            data_q  <= data_d;
            sat_q   <= sat_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_accum_differencer.sv
// Directed bench for accum_differencer with a queue-based scoreboard fed by a
// small behavioural model of the differencer and its output register.
module tb_accum_differencer;

    logic        clk;
    logic        reset;
    logic        clear;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic        out_sat;
    logic [7:0]  sat_count;

    int checks = 0;
    int errors = 0;

    logic [16:0] sb_q[$];
    longint      m_prev;
    bit          m_full;
    int          m_cnt;

    accum_differencer #(.ACCUM_SZ(32), .DATA_SZ(16), .SAT_CNT_SZ(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .clear     (clear),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_sat   (out_sat),
        .sat_count (sat_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        sb_q.delete();
        m_prev = 0;
        m_full = 0;
        m_cnt  = 0;
    endtask

    // One clock cycle: drive, check against the model, update the model, clock.
    task automatic cycle(input bit v, input logic [31:0] d, input bit r, input bit c);
        logic [16:0] exp;
        longint      df;
        bit          exp_rdy;
        in_valid  = v;
        in_data   = d;
        out_ready = r;
        clear     = c;
        #1;
        exp_rdy = !c && (!m_full || r);
        chk("in_ready", 32'(in_ready), 32'(exp_rdy));
        chk("out_valid", 32'(out_valid), 32'(m_full));
        chk("sat_count", 32'(sat_count), 32'(m_cnt));
        if (m_full && sb_q.size() > 0) begin
            chk("out_data", 32'(out_data), 32'(sb_q[0][15:0]));
            chk("out_sat", 32'(out_sat), 32'(sb_q[0][16]));
        end
        if (c) begin
            model_reset();
        end else begin
            if (m_full && r) begin
                void'(sb_q.pop_front());
                m_full = 0;
            end
            if (v && exp_rdy) begin
                df = longint'($signed(d)) - m_prev;
                if (df > 32767)       exp = {1'b1, 16'h7FFF};
                else if (df < -32768) exp = {1'b1, 16'h8000};
                else                  exp = {1'b0, df[15:0]};
                sb_q.push_back(exp);
                m_prev = longint'($signed(d));
                m_full = 1;
                if (exp[16] && m_cnt < 255) m_cnt++;
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        reset     = 1'b0;
        clear     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        model_reset();
        #3;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_out_sat", 32'(out_sat), 32'd0);
        chk("rst_sat_count", 32'(sat_count), 32'd0);
        @(negedge clk);
        reset = 1'b1;

        // Plain stream, one per cycle
        cycle(1, 32'd5, 1, 0);
        cycle(1, 32'd12, 1, 0);
        cycle(1, 32'd12, 1, 0);
        cycle(1, -32'sd4, 1, 0);
        cycle(0, 32'd0, 1, 0);

        // Backpressure
        cycle(0, 32'd0, 1, 1);
        cycle(1, 32'd100, 1, 0);
        for (int i = 0; i < 4; i++) cycle(1, 32'd150, 0, 0);
        cycle(1, 32'd150, 1, 0);
        cycle(0, 32'd0, 1, 0);

        // Saturation both directions
        cycle(0, 32'd0, 1, 1);
        cycle(1, 32'h0001_0000, 1, 0);
        cycle(1, 32'd0, 1, 0);
        cycle(1, 32'd3, 1, 0);
        cycle(0, 32'd0, 1, 0);

        // Full-range extremes
        cycle(0, 32'd0, 1, 1);
        cycle(1, 32'h7FFF_FFFF, 1, 0);
        cycle(1, 32'h8000_0000, 1, 0);
        cycle(0, 32'd0, 1, 0);

        // Clear while output is stalled
        cycle(0, 32'd0, 1, 1);
        cycle(1, 32'd1000, 0, 0);
        cycle(1, 32'd2000, 0, 1);
        cycle(1, 32'd7, 1, 0);
        cycle(0, 32'd0, 1, 0);

        // Counter saturation
        cycle(0, 32'd0, 1, 1);
        for (int i = 0; i < 300; i++) begin
            cycle(1, (i % 2 == 0) ? 32'h0010_0000 : -32'sh0010_0000, 1, 0);
        end
        cycle(0, 32'd0, 1, 0);
        chk("sat_count_max", 32'(sat_count), 32'd255);

        // Async reset with a pending output
        cycle(1, 32'd5, 0, 0);
        #2;
        reset = 1'b0;
        #1;
        chk("arst_out_valid", 32'(out_valid), 32'd0);
        chk("arst_out_data", 32'(out_data), 32'd0);
        chk("arst_out_sat", 32'(out_sat), 32'd0);
        chk("arst_sat_count", 32'(sat_count), 32'd0);
        model_reset();
        @(negedge clk);
        reset = 1'b1;
        cycle(1, 32'd9, 1, 0);
        cycle(0, 32'd0, 1, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
